// File: rtl/motor_ctrl_pkg.sv
// Shared definitions for the motor ramp controller.
//   state_t     : controller states (IDLE, RAMP, RUN, DEAD), 2-bit encoding
//   DUTY_W_DEF  : default duty threshold width (matches the 8-bit PWM counter)
//   DIR_CW/CCW  : direction encodings used on dir_req and the internal direction
package motor_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        RUN  = 2'd2,
        DEAD = 2'd3
    } state_t;

    localparam int DUTY_W_DEF = 8;

    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

endpackage

// File: rtl/motor_step_tick.sv
// Ramp step prescaler.
// Free-running counter 0..STEP_DIV-1; tick is high for the single cycle in
// which the counter sits at STEP_DIV-1, after which it wraps to 0.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset, clears the counter
//   tick : one-cycle pulse every STEP_DIV cycles
module motor_step_tick #(
    parameter int STEP_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    // Keep at least one bit so STEP_DIV == 1 (tick every cycle) still builds.
    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(STEP_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/motor_ramp_ctrl.sv
// DC motor ramp / reversal sequencer.
// Slews the PWM duty threshold toward the requested speed one STEP_SIZE per
// tick, and reverses direction safely: ramp to zero, hold the bridge in its
// dead-time condition for DEAD_CYC cycles, then ramp up the other way.
// Build option: MOTOR_BRAKE_EN - when defined the bridge is driven 1/1
// (active brake) during dead-time; otherwise dead-time is coast (0/0).
// IDLE is always coast.
// Ports:
//   clk         : system clock
//   rst         : synchronous active-high reset, overrides everything
//   en          : motor enable; 0 requests a ramp to stop
//   target_duty : requested duty threshold
//   dir_req     : requested direction (1 = clockwise, 0 = anticlockwise)
//   duty        : current duty threshold to the PWM generator (registered)
//   in1, in2    : H-bridge inputs (registered)
//   at_speed    : high while in RUN (registered)
//   busy        : high while in RAMP or DEAD (registered)
module motor_ramp_ctrl
    import motor_ctrl_pkg::*;
#(
    parameter int DUTY_W    = DUTY_W_DEF,
    parameter int STEP_DIV  = 1000,
    parameter int STEP_SIZE = 1,
    parameter int DEAD_CYC  = 500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DUTY_W-1:0] target_duty,
    input  logic              dir_req,
    output logic [DUTY_W-1:0] duty,
    output logic              in1,
    output logic              in2,
    output logic              at_speed,
    output logic              busy
);

    localparam int DEAD_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

    state_t            state, state_n;
    logic              dir_cur, dir_n;
    logic [DEAD_W-1:0] dead_cnt, dead_n;
    logic [DUTY_W-1:0] duty_n;
    logic [DUTY_W-1:0] eff, goal;
    logic [31:0]       up_diff, dn_diff;
    logic              in1_n, in2_n;
    logic              tick;

    motor_step_tick #(
        .STEP_DIV (STEP_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        state_n = state;
        dir_n   = dir_cur;
        dead_n  = dead_cnt;
        duty_n  = duty;
        in1_n   = 1'b0;
        in2_n   = 1'b0;

        eff = en ? target_duty : '0;
        // A pending reversal forces the goal to zero so we ramp down first.
        goal = (dir_req != dir_cur) ? '0 : eff;

        // Distances done in 32 bits so the saturation test cannot wrap.
        up_diff = 32'(goal) - 32'(duty);
        dn_diff = 32'(duty) - 32'(goal);

        case (state)
            IDLE: begin
                duty_n = '0;
                if (eff != '0) begin
                    state_n = RAMP;
                    dir_n   = dir_req;
                end
            end
            RAMP: begin
                if (duty == goal) begin
                    dead_n = '0;
                    if (goal == '0) begin
                        state_n = (dir_req != dir_cur) ? DEAD : IDLE;
                    end else begin
                        state_n = RUN;
                    end
                end else if (tick) begin
                    if (goal > duty) begin
                        duty_n = (up_diff <= 32'(STEP_SIZE)) ? goal : duty + DUTY_W'(STEP_SIZE);
                    end else begin
                        duty_n = (dn_diff <= 32'(STEP_SIZE)) ? goal : duty - DUTY_W'(STEP_SIZE);
                    end
                end
            end
            RUN: begin
                if ((eff != duty) || (dir_req != dir_cur)) begin
                    state_n = RAMP;
                end
            end
            DEAD: begin
                duty_n = '0;
                if (dead_cnt == DEAD_W'(DEAD_CYC - 1)) begin
                    // Only the direction request present at exit matters.
                    dead_n  = '0;
                    dir_n   = dir_req;
                    state_n = (eff != '0) ? RAMP : IDLE;
                end else begin
                    dead_n = dead_cnt + DEAD_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                duty_n  = '0;
            end
        endcase

        // Bridge outputs follow the next state so they register in step with it.
        if ((state_n == RAMP) || (state_n == RUN)) begin
            in1_n = dir_n;
            in2_n = ~dir_n;
        end
`ifdef MOTOR_BRAKE_EN
        if (state_n == DEAD) begin
            in1_n = 1'b1;
            in2_n = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            dir_cur  <= DIR_CCW;
            dead_cnt <= '0;
            duty     <= '0;
            in1      <= 1'b0;
            in2      <= 1'b0;
            at_speed <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            dir_cur  <= dir_n;
            dead_cnt <= dead_n;
            duty     <= duty_n;
            in1      <= in1_n;
            in2      <= in2_n;
            at_speed <= (state_n == RUN);
            busy     <= (state_n == RAMP) || (state_n == DEAD);
        end
    end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Self-checking bench for motor_ramp_ctrl (STEP_DIV=4, STEP_SIZE=16, DEAD_CYC=3).
// Inputs change on the falling edge; a behavioural reference model advances
// on every rising edge and all outputs are compared on the following falling edge.
module tb_motor_ramp_ctrl;

    localparam int SD = 4;
    localparam int SS = 16;
    localparam int DC = 3;

    localparam int M_STOP = 0;
    localparam int M_SLEW = 1;
    localparam int M_HOLD = 2;
    localparam int M_GAP  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] target_duty;
    logic       dir_req;
    logic [7:0] duty;
    logic       in1, in2, at_speed, busy;

    int checks = 0;
    int passes = 0;

    // reference model state
    int m_mode  = M_STOP;
    int m_duty  = 0;
    int m_dir   = 0;
    int m_phase = 0;
    int m_gap   = 0;

    motor_ramp_ctrl #(
        .DUTY_W    (8),
        .STEP_DIV  (SD),
        .STEP_SIZE (SS),
        .DEAD_CYC  (DC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .target_duty (target_duty),
        .dir_req     (dir_req),
        .duty        (duty),
        .in1         (in1),
        .in2         (in2),
        .at_speed    (at_speed),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One rising edge of the behavioural model, using the inputs held across it.
    task automatic model_edge();
        int tick_now, eff, goal;
        if (rst) begin
            m_mode  = M_STOP;
            m_duty  = 0;
            m_dir   = 0;
            m_phase = 0;
            m_gap   = 0;
            return;
        end
        tick_now = (m_phase == SD - 1);
        m_phase  = (m_phase + 1) % SD;
        eff  = en ? int'(target_duty) : 0;
        goal = (int'(dir_req) != m_dir) ? 0 : eff;
        case (m_mode)
            M_STOP: begin
                if (eff != 0) begin
                    m_mode = M_SLEW;
                    m_dir  = int'(dir_req);
                end
            end
            M_SLEW: begin
                if (m_duty == goal) begin
                    m_gap = 0;
                    if (goal != 0)                    m_mode = M_HOLD;
                    else if (int'(dir_req) != m_dir) m_mode = M_GAP;
                    else                              m_mode = M_STOP;
                end else if (tick_now) begin
                    if (goal > m_duty) m_duty = (m_duty + SS > goal) ? goal : m_duty + SS;
                    else               m_duty = (m_duty - SS < goal) ? goal : m_duty - SS;
                end
            end
            M_HOLD: begin
                if (eff != m_duty || int'(dir_req) != m_dir) m_mode = M_SLEW;
            end
            default: begin
                m_gap++;
                if (m_gap == DC) begin
                    m_dir  = int'(dir_req);
                    m_mode = (eff != 0) ? M_SLEW : M_STOP;
                end
            end
        endcase
    endtask

    function automatic int exp_in1();
        if (m_mode == M_SLEW || m_mode == M_HOLD) return m_dir;
`ifdef MOTOR_BRAKE_EN
        if (m_mode == M_GAP) return 1;
`endif
        return 0;
    endfunction

    function automatic int exp_in2();
        if (m_mode == M_SLEW || m_mode == M_HOLD) return 1 - m_dir;
`ifdef MOTOR_BRAKE_EN
        if (m_mode == M_GAP) return 1;
`endif
        return 0;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("duty",     32'(duty),     32'(m_duty));
        check("in1",      32'(in1),      32'(exp_in1()));
        check("in2",      32'(in2),      32'(exp_in2()));
        check("at_speed", 32'(at_speed), 32'(m_mode == M_HOLD));
        check("busy",     32'(busy),     32'(m_mode == M_SLEW || m_mode == M_GAP));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int seg;
        int pick;

        // 1. reset held with a live request on the inputs
        rst = 1'b1; en = 1'b1; target_duty = 8'd200; dir_req = 1'b1;
        run(2);
        check("reset_duty", 32'(duty), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);

        // 2. start-up to 64 clockwise
        rst = 1'b0; target_duty = 8'd64;
        run(30);
        check("startup_duty", 32'(duty), 32'd64);
        check("startup_at_speed", 32'(at_speed), 32'd1);
        check("startup_in1", 32'(in1), 32'd1);

        // 3. retarget down to 40 (last step saturates), then back up
        target_duty = 8'd40;
        run(20);
        check("retarget_duty", 32'(duty), 32'd40);
        target_duty = 8'd64;
        run(20);

        // 4. reversal to anticlockwise and back
        dir_req = 1'b0;
        run(40);
        check("reverse_duty", 32'(duty), 32'd64);
        check("reverse_in2", 32'(in2), 32'd1);
        check("reverse_in1", 32'(in1), 32'd0);
        dir_req = 1'b1;
        // toggle the request while the bridge is in dead-time
        for (int i = 0; i < 100 && m_mode != M_GAP; i++) step();
        dir_req = 1'b0; step();
        dir_req = 1'b1; step();
        run(40);

        // 5. stop by dropping enable
        en = 1'b0;
        run(30);
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_in1", 32'(in1), 32'd0);

        // 6. reset in the middle of a ramp at duty 32
        en = 1'b1;
        for (int i = 0; i < 100 && !(m_mode == M_SLEW && m_duty == 32); i++) step();
        check("midramp_duty", 32'(duty), 32'd32);
        rst = 1'b1; step();
        check("midramp_rst_duty", 32'(duty), 32'd0);
        rst = 1'b0;
        run(30);

        // 7. randomized segments against the model
        for (int s = 0; s < 80; s++) begin
            pick = int'($urandom_range(0, 5));
            case (pick)
                0:       target_duty = 8'd255;
                1:       target_duty = 8'd0;
                2:       target_duty = 8'(16 * $urandom_range(1, 15));
                default: target_duty = 8'($urandom_range(1, 255));
            endcase
            en      = ($urandom_range(0, 5) != 0);
            dir_req = 1'($urandom_range(0, 1));
            rst     = ($urandom_range(0, 30) == 0);
            if (rst) begin
                step();
                rst = 1'b0;
            end
            seg = int'($urandom_range(1, 40));
            run(seg);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/motor_ramp_ctrl.md
Name: motor_ramp_ctrl

Overview:
Sequences the DC motor PWM datapath. It accepts a requested speed (duty threshold) and direction, ramps the duty threshold at a controlled slew rate, and performs safe reversal. A reversal is done as ramp-down to zero, then a dead-time with both bridge inputs off, then ramp-up in the new direction. It drives the PWM generator's duty threshold and the H-bridge IN1/IN2 lines, and sits between the user controls (switches/buttons) and the PWM block.

Parameters:
DUTY_W, 8, width of duty threshold; matches the PWM 8-bit counter.
STEP_DIV, 1000, clock cycles per ramp step (tick period); must be >= 1.
STEP_SIZE, 1, duty increment/decrement per tick; must be >= 1.
DEAD_CYC, 500, clock cycles with bridge off between direction changes; must be >= 1.

Ports:
clk  in  1  system clock; the single clock for the block
rst  in  1  reset; synchronous, active-high
en  in  1  motor enable; 0 requests ramp to stop
target_duty  in  DUTY_W  requested duty threshold; higher means more PWM high time
dir_req  in  1  requested direction; 1 = clockwise, 0 = anticlockwise
duty  out  DUTY_W  current duty threshold fed to the PWM generator
in1  out  1  H-bridge IN1
in2  out  1  H-bridge IN2
at_speed  out  1  high while in RUN
busy  out  1  high while in RAMP or DEAD

Behaviour:
- All outputs are registered. Reset values: duty=0, in1=0, in2=0, at_speed=0, busy=0, state=IDLE, dir_cur=0, tick and dead counters = 0. rst wins over all other inputs.
- tick: the prescaler counts 0..STEP_DIV-1 and pulses one cycle at STEP_DIV-1, then wraps to 0. It is free-running and cleared only by rst.
- eff = en ? target_duty : 0. goal = (dir_req != dir_cur) ? 0 : eff. Both are re-evaluated every cycle, so target changes mid-ramp are followed.
- State IDLE: duty=0, in1=in2=0. If eff != 0, go to RAMP next cycle with dir_cur <= dir_req.
- State RAMP: in1=dir_cur, in2=~dir_cur. On tick, duty moves toward goal by STEP_SIZE.
  - The step saturates: if |goal-duty| <= STEP_SIZE, then duty <= goal. There is no overshoot and no wrap past 0 or 2^DUTY_W-1.
  - When duty == goal (checked every cycle), the next state is:
    - DEAD if goal==0 and dir_req != dir_cur;
    - else IDLE if goal==0;
    - else RUN.
- State RUN: duty holds; at_speed=1. If eff != duty or dir_req != dir_cur, go to RAMP next cycle.
- State DEAD: duty=0, in1=in2=0 for exactly DEAD_CYC cycles.
  - On exit, dir_cur <= dir_req sampled at the exit cycle.
  - Next state is RAMP if eff != 0, else IDLE.
  - dir_req toggling during DEAD is harmless; only the exit value matters.
- busy = (state==RAMP || state==DEAD).
- Latency:
  - en rising with target != 0 (from IDLE): in1/in2 become valid 1 cycle later.
  - The first duty change occurs on the first tick after entering RAMP.
- in1 and in2 are never both driven to opposite-active polarity without passing through DEAD when the direction changes.
- rst mid-operation: duty=0 and in1=in2=0 on the next edge, regardless of state.

Optional Feature:
MOTOR_BRAKE_EN
- Defined: during DEAD, in1=in2=1 (active brake); IDLE remains coast (0/0).
- Undefined: DEAD drives in1=in2=0 (coast). All other behaviour is identical.

Decomposition:
- Package motor_ctrl_pkg holds:
  - the state enum (IDLE, RAMP, RUN, DEAD, 2-bit);
  - DUTY_W default;
  - direction constants DIR_CW=1, DIR_CCW=0.
- One sub-module, motor_step_tick: the STEP_DIV prescaler producing the one-cycle tick pulse.

Test Plan:
Bench parameters: STEP_DIV=4, STEP_SIZE=16, DEAD_CYC=3.
1. Reset: assert rst for 2 cycles with en=1, target=200 -> duty=0, in1=in2=0, busy=0, at_speed=0 throughout.
2. Start-up: en=1, target=64, dir=1 -> next cycle in1=1, in2=0, busy=1; duty steps 16, 32, 48, 64 on successive ticks (4 cycles apart); then at_speed=1; duty never exceeds 64.
3. Retarget down: from RUN at 64, set target=40 -> duty 48, then 40 (saturated step), then RUN; at_speed low during the ramp.
4. Reversal: from RUN at 64, dir=1, toggle dir_req to 0 -> duty 48, 32, 16, 0; then in1=in2=0 for exactly 3 cycles; then in1=0, in2=1; duty ramps back to 64. Repeat with MOTOR_BRAKE_EN -> in1=in2=1 during those 3 cycles.
5. Stop: from RUN at 64, drop en -> duty ramps to 0; then IDLE with in1=in2=0, busy=0.
6. Reset mid-ramp: pulse rst while duty=32 in RAMP -> duty=0, in1=in2=0 next edge; the block restarts from IDLE after rst is released.
